// File: rtl/gardner_ted_pkg.sv
// Shared width helpers and parameter sanity checks for the complex Gardner timing-error detector.
package gardner_ted_pkg;

  function automatic int diff_width(input int in_w);
    return in_w + 1;
  endfunction

  function automatic int prod_width(input int in_w);
    return 2 * in_w + 1;
  endfunction

  function automatic int min_out_width(input int in_w);
    return 2 * in_w + 2;
  endfunction

  function automatic bit sps_valid(input int sps);
    return (sps >= 2) && (sps % 2 == 0);
  endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Per-rail sample delay line; shifts only on accepted samples.
module sample_delay_line #(
  parameter int Width = 12,
  parameter int Depth = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [Width-1:0]             in,
  input  logic                         in_valid,
  output logic [Depth-1:0][Width-1:0]  taps
);

  logic [Depth-1:1][Width-1:0] taps_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q <= '0;
    end else if (in_valid) begin
      taps_q[1] <= in;
      for (int unsigned k = 2; k < Depth; k++) begin
        taps_q[k] <= taps_q[k-1];
      end
    end
  end

  // tap0 is the sample presented this cycle, so older taps read pre-shift history
  assign taps = {taps_q, in};

endmodule

// File: rtl/gardner_ted_iq.sv
// Pipelined complex Gardner timing-error detector with valid/ready output and sticky overrun.
module gardner_ted_iq
  import gardner_ted_pkg::*;
#(
  parameter int SamplesPerSymbol = 4,
  parameter int InputLengthBits  = 12,
  parameter int OutputLengthBits = 26,
  parameter int ComplexMode      = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic signed [InputLengthBits-1:0]  i_in,
  input  logic signed [InputLengthBits-1:0]  q_in,
  input  logic                               in_valid,
  input  logic                               trigger,
  output logic signed [OutputLengthBits-1:0] out,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               overrun
);

  localparam int IW    = InputLengthBits;
  localparam int OW    = OutputLengthBits;
  localparam int DW    = diff_width(IW);
  localparam int PW    = prod_width(IW);
  localparam int Depth = SamplesPerSymbol + 1;
  localparam int Half  = SamplesPerSymbol / 2;

  if (!sps_valid(SamplesPerSymbol)) begin : g_bad_sps
    $error("SamplesPerSymbol must be even and >= 2");
  end
  if (OW < min_out_width(IW)) begin : g_bad_ow
    $error("OutputLengthBits must be >= 2*InputLengthBits+2");
  end

  logic [Depth-1:0][IW-1:0] i_taps, q_taps;

  sample_delay_line #(.Width(IW), .Depth(Depth)) u_i_line (
    .clk(clk), .rst(rst), .in(i_in), .in_valid(in_valid), .taps(i_taps)
  );

  if (ComplexMode != 0) begin : g_q_line
    sample_delay_line #(.Width(IW), .Depth(Depth)) u_q_line (
      .clk(clk), .rst(rst), .in(q_in), .in_valid(in_valid), .taps(q_taps)
    );
  end else begin : g_no_q
    logic unused_q_in;
    assign q_taps      = '0;
    assign unused_q_in = ^q_in;
  end

  logic unused_taps;
  assign unused_taps = ^{i_taps, q_taps};

  logic                 accept;
  logic signed [DW-1:0] diff_i_d, diff_q_d, diff_i_q, diff_q_q;
  logic signed [IW-1:0] mid_i_q, mid_q_q;
  logic                 v1_q, v2_q;
  logic signed [PW-1:0] prod_i_d, prod_q_d, prod_i_q, prod_q_q;
  logic signed [OW-1:0] sum_d, out_q;
  logic                 out_valid_q, overrun_q;

  assign accept = in_valid & trigger;

  always_comb begin
    diff_i_d = DW'($signed(i_taps[SamplesPerSymbol])) - DW'($signed(i_taps[0]));
    diff_q_d = DW'($signed(q_taps[SamplesPerSymbol])) - DW'($signed(q_taps[0]));
    prod_i_d = PW'(diff_i_q) * PW'(mid_i_q);
    prod_q_d = PW'(diff_q_q) * PW'(mid_q_q);
    sum_d    = OW'(prod_i_q) + OW'(prod_q_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_i_q <= '0;
      diff_q_q <= '0;
      mid_i_q  <= '0;
      mid_q_q  <= '0;
      v1_q     <= 1'b0;
      prod_i_q <= '0;
      prod_q_q <= '0;
      v2_q     <= 1'b0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        diff_i_q <= diff_i_d;
        diff_q_q <= diff_q_d;
        mid_i_q  <= $signed(i_taps[Half]);
        mid_q_q  <= $signed(q_taps[Half]);
      end
      v2_q <= v1_q;
      if (v1_q) begin
        prod_i_q <= prod_i_d;
        prod_q_q <= prod_q_d;
      end
    end
  end

  // A fresh result always wins over the handshake; overrun only when it clobbers an unread one
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (v2_q) begin
      out_q       <= sum_d;
      out_valid_q <= 1'b1;
      if (out_valid_q && !out_ready) begin
        overrun_q <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_gardner_ted_iq.sv
// Self-checking bench: complex and I-only builds driven together against a sample-history model.
module tb_gardner_ted_iq;

  localparam int SPS = 4;
  localparam int IW  = 12;
  localparam int OW  = 26;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, trigger, out_ready;
  logic signed [IW-1:0] i_in, q_in;
  logic signed [OW-1:0] out_c, out_r;
  logic                 ov_c, ov_r, ovr_c, ovr_r;

  gardner_ted_iq #(.SamplesPerSymbol(SPS), .InputLengthBits(IW),
                   .OutputLengthBits(OW), .ComplexMode(1)) dut (
    .clk(clk), .rst(rst), .i_in(i_in), .q_in(q_in), .in_valid(in_valid),
    .trigger(trigger), .out(out_c), .out_valid(ov_c), .out_ready(out_ready),
    .overrun(ovr_c)
  );

  gardner_ted_iq #(.SamplesPerSymbol(SPS), .InputLengthBits(IW),
                   .OutputLengthBits(OW), .ComplexMode(0)) dut_r (
    .clk(clk), .rst(rst), .i_in(i_in), .q_in(q_in), .in_valid(in_valid),
    .trigger(trigger), .out(out_r), .out_valid(ov_r), .out_ready(out_ready),
    .overrun(ovr_r)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int ec; int er; } res_t;

  int   hist_i[$], hist_q[$];
  res_t pend[$];
  int   cyc = 0;
  int   exp_c = 0, exp_r = 0;
  bit   exp_v = 1'b0, exp_o = 1'b0;
  int   passed = 0, total = 0;

  function automatic int tap(input int h[$], input int k);
    if (k < h.size()) return h[h.size()-1-k];
    return 0;
  endfunction

  function automatic int rnd();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  // Drive one cycle and advance the model: results appear two edges after acceptance.
  task automatic step(input bit r, input int iv, input int qv, input bit v, input bit t, input bit rdy);
    res_t x;
    int   ei, eq;
    rst = r; i_in = IW'(iv); q_in = IW'(qv); in_valid = v; trigger = t; out_ready = rdy;
    @(posedge clk);
    if (r) begin
      hist_i.delete(); hist_q.delete(); pend.delete();
      exp_c = 0; exp_r = 0; exp_v = 1'b0; exp_o = 1'b0;
    end else begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
        x = pend.pop_front();
        if (exp_v && !rdy) exp_o = 1'b1;
        exp_c = x.ec; exp_r = x.er; exp_v = 1'b1;
      end else if (rdy) begin
        exp_v = 1'b0;
      end
      if (v) begin
        hist_i.push_back(iv); hist_q.push_back(qv);
        if (hist_i.size() > SPS + 1) begin
          void'(hist_i.pop_front()); void'(hist_q.pop_front());
        end
        if (t) begin
          ei = (tap(hist_i, SPS) - tap(hist_i, 0)) * tap(hist_i, SPS/2);
          eq = (tap(hist_q, SPS) - tap(hist_q, 0)) * tap(hist_q, SPS/2);
          pend.push_back('{cyc + 2, ei + eq, ei});
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 1000; n++) begin
      step(1'b1, rnd(), rnd(), 1'b1, 1'(($urandom)), 1'(($urandom)));
      total++;
      if ({out_c, out_r, ov_c, ov_r, ovr_c, ovr_r} !== '0)
        $display("FAIL reset cyc=%0d got out=%0d/%0d v=%b%b ovr=%b%b exp all zero",
                 cyc, out_c, out_r, ov_c, ov_r, ovr_c, ovr_r);
      else passed++;
    end
    for (int n = 0; n < 20; n++) begin
      step(1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
      total++;
      if (out_c !== '0 || out_r !== '0 || ov_c !== (n >= 2) || ovr_c !== 1'b0)
        $display("FAIL zero_input n=%0d got out=%0d/%0d v=%b ovr=%b exp out=0 v=%b ovr=0",
                 n, out_c, out_r, ov_c, ovr_c, (n >= 2));
      else passed++;
    end
  endtask

  task automatic test_step(input bit cplx);
    int pk_c, pk_r;
    pk_c = cplx ? -8380418 : -4190209;
    pk_r = -4190209;
    for (int n = 0; n < 3; n++) step(1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 107; j++) begin
      step(1'b0, 2047, cplx ? 2047 : 0, 1'b1, 1'b1, 1'b1);
      total++;
      if (out_c !== OW'((j == 4 || j == 5) ? pk_c : 0) ||
          out_r !== OW'((j == 4 || j == 5) ? pk_r : 0) ||
          ov_c !== (j >= 2) || ov_r !== (j >= 2) || ovr_c !== 1'b0)
        $display("FAIL step_%s j=%0d got out=%0d/%0d v=%b%b ovr=%b exp out=%0d/%0d v=%b ovr=0",
                 cplx ? "cplx" : "real", j, out_c, out_r, ov_c, ov_r, ovr_c,
                 (j == 4 || j == 5) ? pk_c : 0, (j == 4 || j == 5) ? pk_r : 0, (j >= 2));
      else passed++;
    end
  endtask

  task automatic test_overflow();
    int tab_c[8] = '{0, 0, 0, 0, -8388608, -8388608, 0, 16773120};
    int tab_r[8] = '{0, 0, 0, 0, -4194304, -4194304, 0, 8386560};
    for (int n = 0; n < 3; n++) step(1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 8; j++) begin
      step(1'b0, (j < 5) ? -2048 : 2047, (j < 5) ? -2048 : 2047, 1'b1, 1'b1, 1'b1);
      total++;
      if (out_c !== OW'(tab_c[j]) || out_r !== OW'(tab_r[j]))
        $display("FAIL overflow j=%0d got out=%0d/%0d exp out=%0d/%0d",
                 j, out_c, out_r, tab_c[j], tab_r[j]);
      else passed++;
    end
  endtask

  task automatic test_gating();
    int  cnt;
    bit  v;
    cnt = 0;
    for (int n = 0; n < 3; n++) step(1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 300; n++) begin
      v = ($urandom_range(3) != 0);
      step(1'b0, -1000 + 2 * cnt, rnd(), v, 1'(($urandom)), 1'b1);
      if (v) cnt++;
      total++;
      if ({out_c, out_r, ov_c, ov_r, ovr_c, ovr_r} !== {OW'(exp_c), OW'(exp_r), exp_v, exp_v, exp_o, exp_o})
        $display("FAIL ramp_gaps cyc=%0d got out=%0d/%0d v=%b%b ovr=%b%b exp out=%0d/%0d v=%b ovr=%b",
                 cyc, out_c, out_r, ov_c, ov_r, ovr_c, ovr_r, exp_c, exp_r, exp_v, exp_o);
      else passed++;
    end
    for (int n = 0; n < 12; n++) begin
      step(1'b0, rnd(), rnd(), 1'b0, 1'b1, 1'b1);
      total++;
      if ((n >= 3 && (ov_c !== 1'b0 || ov_r !== 1'b0)) || ov_c !== exp_v)
        $display("FAIL trig_no_valid n=%0d got v=%b%b exp v=%b", n, ov_c, ov_r, exp_v);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 3; n++) step(1'b1, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) step(1'b0, rnd(), rnd(), 1'b1, 1'b0, 1'b0);
    step(1'b0, rnd(), rnd(), 1'b1, 1'b1, 1'b0);
    step(1'b0, rnd(), rnd(), 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) step(1'b0, rnd(), rnd(), 1'b0, 1'b0, 1'b0);
    total++;
    if (ov_c !== 1'b1 || ovr_c !== 1'b1 || ovr_r !== 1'b1 || out_c !== OW'(exp_c) || out_r !== OW'(exp_r))
      $display("FAIL overrun_set got out=%0d/%0d v=%b ovr=%b%b exp out=%0d/%0d v=1 ovr=1",
               out_c, out_r, ov_c, ovr_c, ovr_r, exp_c, exp_r);
    else passed++;
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) begin
      step(1'b0, rnd(), rnd(), 1'b0, 1'b0, 1'(($urandom)));
      total++;
      if (ov_c !== 1'b0 || ovr_c !== 1'b1 || out_c !== OW'(exp_c))
        $display("FAIL overrun_sticky n=%0d got out=%0d v=%b ovr=%b exp out=%0d v=0 ovr=1",
                 n, out_c, ov_c, ovr_c, exp_c);
      else passed++;
    end
    step(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (ovr_c !== 1'b0 || ovr_r !== 1'b0 || out_c !== '0)
      $display("FAIL overrun_clear got out=%0d ovr=%b%b exp out=0 ovr=0", out_c, ovr_c, ovr_r);
    else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(299) == 0), rnd(), rnd(), ($urandom_range(4) != 0),
           ($urandom_range(2) != 0), ($urandom_range(3) != 0));
      total++;
      if ({out_c, out_r, ov_c, ov_r, ovr_c, ovr_r} !== {OW'(exp_c), OW'(exp_r), exp_v, exp_v, exp_o, exp_o})
        $display("FAIL random cyc=%0d got out=%0d/%0d v=%b%b ovr=%b%b exp out=%0d/%0d v=%b ovr=%b",
                 cyc, out_c, out_r, ov_c, ov_r, ovr_c, ovr_r, exp_c, exp_r, exp_v, exp_o);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; i_in = '0; q_in = '0; in_valid = 1'b0; trigger = 1'b0; out_ready = 1'b0;
    test_reset();
    test_step(1'b0);
    test_step(1'b1);
    test_overflow();
    test_gating();
    test_backpressure();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
